// File: rtl/dconv_pkg.sv
// Shared definitions for the I/Q integrate-and-dump decimator.
// Contents: FSM state encoding, default datapath widths and a sign-extension
// helper for widening downconverter samples to accumulator width.
package dconv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dconv_state_t;

    localparam int DEF_DATA_WIDTH = 15;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_FRM_WIDTH  = 16;

    // Widen a default-width signed sample to the default accumulator width.
    function automatic logic [DEF_ACC_WIDTH-1:0] sext_data(input logic [DEF_DATA_WIDTH-1:0] d);
        return {{(DEF_ACC_WIDTH-DEF_DATA_WIDTH){d[DEF_DATA_WIDTH-1]}}, d};
    endfunction

endpackage

// File: rtl/iq_accum_lane.sv
// One signed integrate-and-dump lane (instantiated once for I, once for Q).
// Ports:
//   CLK, RESET      clock, asynchronous active-high reset
//   i_clear         zero the accumulator (highest priority)
//   i_dump          load o_sum with acc + sample and restart the accumulator at 0
//   i_add           add sample into the accumulator
//   i_data          signed sample, DATA_WIDTH bits
//   o_sum           registered signed dump value, ACC_WIDTH bits
module iq_accum_lane
    import dconv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_clear,
    input  logic                  i_add,
    input  logic                  i_dump,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [ACC_WIDTH-1:0]  o_sum
);

    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] w_acc_plus;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_sum;

    generate
        if (DATA_WIDTH == DEF_DATA_WIDTH && ACC_WIDTH == DEF_ACC_WIDTH) begin : g_pkg_ext
            assign w_ext = sext_data(i_data);
        end else begin : g_gen_ext
            assign w_ext = {{(ACC_WIDTH-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};
        end
    endgenerate

    // Dump folds the current sample in directly so the frame boundary costs no sample.
    assign w_acc_plus = r_acc + w_ext;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_acc <= '0;
            r_sum <= '0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_dump) begin
                r_sum <= w_acc_plus;
                r_acc <= '0;
            end else if (i_add) begin
                r_acc <= w_acc_plus;
            end
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/dconv_iq_accum_dump.sv
// I/Q integrate-and-dump decimator behind the 4-phase downconverter.
// Sums dec_factor samples per channel and offers each sum on a valid/ready
// port; stops after num_frames outputs and pulses o_done.
// Ports:
//   CLK, RESET             clock, asynchronous active-high reset
//   i_data_i, i_data_q     signed samples, valid when i_conv_en=1
//   i_start, i_abort       one-cycle acquisition control pulses
//   i_dec_factor           samples per output (0 acts as 1), latched at start
//   i_num_frames           outputs per acquisition (0 acts as 1), latched at start
//   o_sum_i, o_sum_q       signed sums
//   o_out_valid/i_out_ready output handshake
//   o_busy                 acquisition in progress (RUN or DRAIN)
//   o_done                 one-cycle end-of-acquisition pulse
//   o_overflow             sticky: an unaccepted output was overwritten
//
// state | meaning
// IDLE  | waiting for start, conv_en ignored
// RUN   | integrating samples, dumping every dec_factor samples
// DRAIN | all frames dumped, waiting for the last output to be accepted
module dconv_iq_accum_dump
    import dconv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int FRM_WIDTH  = DEF_FRM_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] i_data_i,
    input  logic [DATA_WIDTH-1:0] i_data_q,
    input  logic                  i_conv_en,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [CNT_WIDTH-1:0]  i_dec_factor,
    input  logic [FRM_WIDTH-1:0]  i_num_frames,
    output logic [ACC_WIDTH-1:0]  o_sum_i,
    output logic [ACC_WIDTH-1:0]  o_sum_q,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    dconv_state_t r_state;
    dconv_state_t w_state_nxt;

    logic [CNT_WIDTH-1:0] r_dec;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [FRM_WIDTH-1:0] r_nfrm;
    logic [FRM_WIDTH-1:0] r_frm;
    logic                 r_valid;
    logic                 r_ovf;
    logic                 r_done;

    logic w_sample;
    logic w_last;
    logic w_last_frame;
    logic w_accept;

    logic w_lane_clr;
    logic w_lane_add;
    logic w_lane_dump;
    logic w_acq_start;
    logic w_done_nxt;

    assign w_sample     = (r_state == ST_RUN) && i_conv_en;
    assign w_last       = w_sample && (r_cnt == (r_dec - CNT_WIDTH'(1)));
    assign w_last_frame = (r_frm == (r_nfrm - FRM_WIDTH'(1)));
    assign w_accept     = r_valid && i_out_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_last && w_last_frame) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_valid || w_accept) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (i_abort) w_state_nxt = ST_IDLE;
    end

    always_comb begin
        w_acq_start = (r_state == ST_IDLE) && i_start && !i_abort;
        w_lane_clr  = i_abort || w_acq_start;
        w_lane_add  = w_sample && !i_abort;
        w_lane_dump = w_last && !i_abort;
        w_done_nxt  = (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE) && !i_abort;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_dec   <= '0;
            r_nfrm  <= '0;
            r_cnt   <= '0;
            r_frm   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_done_nxt;

            if (w_acq_start) begin
                r_dec  <= (i_dec_factor == '0) ? CNT_WIDTH'(1) : i_dec_factor;
                r_nfrm <= (i_num_frames == '0) ? FRM_WIDTH'(1) : i_num_frames;
                r_cnt  <= '0;
                r_frm  <= '0;
            end else if (i_abort) begin
                r_cnt <= '0;
                r_frm <= '0;
            end else if (w_lane_dump) begin
                r_cnt <= '0;
                r_frm <= r_frm + FRM_WIDTH'(1);
            end else if (w_lane_add) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end

            // A dump in the accept cycle keeps valid high with the new sum.
            if (i_abort) begin
                r_valid <= 1'b0;
            end else if (w_lane_dump) begin
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            if (w_acq_start) begin
                r_ovf <= 1'b0;
            end else if (w_lane_dump && r_valid && !i_out_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    iq_accum_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane_i (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_clear (w_lane_clr),
        .i_add   (w_lane_add),
        .i_dump  (w_lane_dump),
        .i_data  (i_data_i),
        .o_sum   (o_sum_i)
    );

    iq_accum_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane_q (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_clear (w_lane_clr),
        .i_add   (w_lane_add),
        .i_dump  (w_lane_dump),
        .i_data  (i_data_q),
        .o_sum   (o_sum_q)
    );

    assign o_out_valid = r_valid;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_dconv_iq_accum_dump.sv
module tb_dconv_iq_accum_dump;

    localparam int DW = 15;
    localparam int CW = 16;
    localparam int AW = 32;
    localparam int FW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] i_data_i;
    logic [DW-1:0] i_data_q;
    logic          i_conv_en;
    logic          i_start;
    logic          i_abort;
    logic [CW-1:0] i_dec_factor;
    logic [FW-1:0] i_num_frames;
    logic [AW-1:0] o_sum_i;
    logic [AW-1:0] o_sum_q;
    logic          o_out_valid;
    logic          i_out_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;

    int n_total = 0;
    int n_bad   = 0;

    dconv_iq_accum_dump #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .ACC_WIDTH  (AW),
        .FRM_WIDTH  (FW)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_data_i     (i_data_i),
        .i_data_q     (i_data_q),
        .i_conv_en    (i_conv_en),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_dec_factor (i_dec_factor),
        .i_num_frames (i_num_frames),
        .o_sum_i      (o_sum_i),
        .o_sum_q      (o_sum_q),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input int di, input int dq);
        i_conv_en = en;
        i_data_i  = DW'(di);
        i_data_q  = DW'(dq);
    endtask

    task automatic start_acq(input int dec, input int nf);
        i_dec_factor = CW'(dec);
        i_num_frames = FW'(nf);
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    function automatic longint si();
        return longint'($signed(o_sum_i));
    endfunction

    function automatic longint sq();
        return longint'($signed(o_sum_q));
    endfunction

    initial begin
        RESET = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_out_ready = 1'b1;
        i_dec_factor = '0;
        i_num_frames = '0;
        drive(1'b0, 0, 0);

        // reset with conv_en toggling
        for (int k = 0; k < 4; k++) begin
            drive(k[0], 7, -7);
            tick();
        end
        chk("rst_valid", o_out_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_sum_i", si(), 0);
        chk("rst_sum_q", sq(), 0);
        RESET = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 9, -9);
            tick();
        end
        chk("idle_valid", o_out_valid, 0);
        chk("idle_busy", o_busy, 0);
        chk("idle_sum_i", si(), 0);

        // basic dump: 4 samples/frame, 2 frames
        drive(1'b0, 0, 0);
        start_acq(4, 2);
        chk("basic_busy", o_busy, 1);
        drive(1'b1, 100, -50);
        for (int k = 0; k < 3; k++) tick();
        chk("basic_valid_early", o_out_valid, 0);
        tick();
        chk("basic_valid1", o_out_valid, 1);
        chk("basic_sum_i1", si(), 400);
        chk("basic_sum_q1", sq(), -200);
        tick();
        chk("basic_valid_drop", o_out_valid, 0);
        tick(); tick();
        chk("basic_valid_early2", o_out_valid, 0);
        tick();
        chk("basic_valid2", o_out_valid, 1);
        chk("basic_sum_i2", si(), 400);
        chk("basic_sum_q2", sq(), -200);
        chk("basic_busy_drain", o_busy, 1);
        tick();
        chk("basic_done", o_done, 1);
        chk("basic_valid_end", o_out_valid, 0);
        chk("basic_idle", o_busy, 0);
        tick();
        chk("basic_done_pulse", o_done, 0);
        chk("basic_busy_end", o_busy, 0);

        // gapped input
        drive(1'b0, 0, 0);
        start_acq(3, 1);
        drive(1'b1, 1, -1);   tick();
        drive(1'b0, 99, 99);  tick();
        drive(1'b1, 2, -2);   tick();
        drive(1'b0, 99, 99);  tick();
        drive(1'b0, 99, 99);  tick();
        chk("gap_valid_early", o_out_valid, 0);
        drive(1'b1, 3, -3);   tick();
        chk("gap_valid", o_out_valid, 1);
        chk("gap_sum_i", si(), 6);
        chk("gap_sum_q", sq(), -6);
        drive(1'b0, 0, 0);
        tick();
        chk("gap_done", o_done, 1);

        // back-pressure and overwrite
        i_out_ready = 1'b0;
        start_acq(2, 3);
        chk("bp_ovf_clear", o_overflow, 0);
        drive(1'b1, 1, 0);    tick();
        drive(1'b1, 2, 0);    tick();
        chk("bp_valid1", o_out_valid, 1);
        chk("bp_sum1", si(), 3);
        chk("bp_ovf0", o_overflow, 0);
        drive(1'b1, 10, 0);   tick();
        chk("bp_hold_sum", si(), 3);
        chk("bp_hold_valid", o_out_valid, 1);
        drive(1'b1, 20, 0);   tick();
        chk("bp_sum2", si(), 30);
        chk("bp_valid2", o_out_valid, 1);
        chk("bp_ovf1", o_overflow, 1);
        i_out_ready = 1'b1;
        drive(1'b1, 100, 0);  tick();
        chk("bp_accept_drop", o_out_valid, 0);
        i_out_ready = 1'b0;
        drive(1'b1, 200, 0);  tick();
        chk("bp_sum3", si(), 300);
        chk("bp_valid3", o_out_valid, 1);
        drive(1'b1, 5, 0);
        tick(); tick();
        chk("bp_drain_wait", o_busy, 1);
        chk("bp_drain_sum", si(), 300);
        chk("bp_drain_nodone", o_done, 0);
        i_out_ready = 1'b1;
        tick();
        chk("bp_done", o_done, 1);
        chk("bp_idle", o_busy, 0);
        chk("bp_ovf_sticky", o_overflow, 1);

        // extremes: full-scale negative over 65535 samples
        drive(1'b0, 0, 0);
        start_acq(65535, 1);
        chk("ext_ovf_cleared", o_overflow, 0);
        drive(1'b1, -16384, 16383);
        for (int k = 0; k < 65534; k++) tick();
        chk("ext_valid_early", o_out_valid, 0);
        tick();
        chk("ext_valid", o_out_valid, 1);
        chk("ext_sum_i", si(), -64'sd1073725440);
        chk("ext_sum_q", sq(), 64'sd1073659905);
        tick();
        chk("ext_done", o_done, 1);

        // dec_factor=0 behaves as 1
        drive(1'b0, 0, 0);
        start_acq(0, 3);
        drive(1'b1, 5, -5);  tick();
        chk("dec0_sum1", si(), 5);
        chk("dec0_valid1", o_out_valid, 1);
        drive(1'b1, 7, -7);  tick();
        chk("dec0_sum2", si(), 7);
        chk("dec0_valid2", o_out_valid, 1);
        drive(1'b1, 9, -9);  tick();
        chk("dec0_sum3", si(), 9);
        chk("dec0_q3", sq(), -9);
        tick();
        chk("dec0_done", o_done, 1);
        chk("dec0_ovf", o_overflow, 0);

        // abort after 5 of 8 samples
        drive(1'b0, 0, 0);
        start_acq(8, 1);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, k, -k);
            tick();
        end
        drive(1'b1, 6, -6);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_valid", o_out_valid, 0);
        chk("abort_done", o_done, 0);
        tick();
        chk("abort_done_later", o_done, 0);
        chk("abort_valid_later", o_out_valid, 0);
        drive(1'b0, 0, 0);
        start_acq(8, 1);
        for (int k = 10; k <= 17; k++) begin
            drive(1'b1, k, -k);
            tick();
        end
        chk("restart_valid", o_out_valid, 1);
        chk("restart_sum_i", si(), 108);
        chk("restart_sum_q", sq(), -108);
        drive(1'b0, 0, 0);
        tick();
        chk("restart_done", o_done, 1);

        // asynchronous reset mid-acquisition
        i_out_ready = 1'b0;
        start_acq(2, 4);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3, 4);
            tick();
        end
        chk("arst_pre_valid", o_out_valid, 1);
        chk("arst_pre_ovf", o_overflow, 1);
        chk("arst_pre_sum", si(), 6);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_valid", o_out_valid, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_ovf", o_overflow, 0);
        chk("arst_sum_i", si(), 0);
        chk("arst_sum_q", sq(), 0);
        #1;
        RESET = 1'b0;
        tick(); tick();
        chk("arst_after_busy", o_busy, 0);
        chk("arst_after_valid", o_out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
